// File: rtl/hex_scan_if.sv
// Bundle between the scan controller and its value/driver side: value inputs in, serial-driver frame out.
interface hex_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      disp_en;
    logic [4*NUM_DIGITS-1:0]   hex_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [15:0]               frame_data;
    logic                      frame_ld;
    logic [2:0]                digit_idx;
    logic                      round_done;

    modport master (
        input  disp_en, hex_in, dp_in, blank_in,
        output frame_data, frame_ld, digit_idx, round_done
    );

    modport slave (
        output disp_en, hex_in, dp_in, blank_in,
        input  frame_data, frame_ld, digit_idx, round_done
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: snapshots a hex word once per round and emits one
// {seg, sel} frame per digit with a load strobe, dwelling SCAN_DIV clocks per digit.
module hex_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    hex_scan_if.master  bus
);
    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 2);
    localparam logic [2:0]      IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [15:0]     FRAME_RST = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    typedef enum logic [1:0] {S_SNAP, S_LOAD, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    en_q, en_d;
    logic [15:0]             frame_q, frame_d;
    logic                    ld_q, ld_d;
    logic [2:0]              didx_q, didx_d;
    logic                    done_q, done_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    // Frame is built active-high and inverted at the end for common-anode parts.
    function automatic logic [15:0] build_frame(
        input logic [2:0]              idx,
        input logic [4*NUM_DIGITS-1:0] hex,
        input logic [NUM_DIGITS-1:0]   dps,
        input logic [NUM_DIGITS-1:0]   blanks,
        input logic                    en
    );
        logic [3:0] nib;
        logic       dp;
        logic       blk;
        logic [7:0] seg;
        logic [7:0] sel;
        nib = '0;
        dp  = 1'b0;
        blk = 1'b0;
        sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (3'(k) == idx) begin
                nib    = hex[4*k +: 4];
                dp     = dps[k];
                blk    = blanks[k];
                sel[k] = 1'b1;
            end
        end
        seg = blk ? 8'h00 : {dp, seg7(nib)};
        if (!en) begin
            seg = 8'h00;
            sel = 8'h00;
        end
        build_frame = ACTIVE_LOW ? ~{seg, sel} : {seg, sel};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SNAP;
            cnt_q   <= '0;
            idx_q   <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            en_q    <= 1'b0;
            frame_q <= FRAME_RST;
            ld_q    <= 1'b0;
            didx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            frame_q <= frame_d;
            ld_q    <= ld_d;
            didx_q  <= didx_d;
            done_q  <= done_d;
        end
    end

    // done_d looks one cycle ahead so round_done shows during the final hold cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hex_d   = hex_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        en_d    = en_q;
        frame_d = frame_q;
        ld_d    = 1'b0;
        didx_d  = didx_q;
        done_d  = 1'b0;
        case (state_q)
            S_SNAP: begin
                hex_d   = bus.hex_in;
                dp_d    = bus.dp_in;
                blank_d = bus.blank_in;
                en_d    = bus.disp_en;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                frame_d = build_frame(idx_q, hex_q, dp_q, blank_q, en_q);
                ld_d    = 1'b1;
                didx_d  = idx_q;
                cnt_d   = '0;
                state_d = S_HOLD;
                done_d  = (CNT_LAST == '0) && (idx_q == IDX_LAST);
            end
            S_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_SNAP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    done_d = (cnt_d == CNT_LAST) && (idx_q == IDX_LAST);
                end
            end
            default: state_d = S_SNAP;
        endcase
    end

    assign bus.frame_data = frame_q;
    assign bus.frame_ld   = ld_q;
    assign bus.digit_idx  = didx_q;
    assign bus.round_done = done_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: two instances (8 digits active-low, 4 digits active-high) run side by side
// against a round-position reference model.
module tb_hex_scan_ctrl;
    localparam int ND [2] = '{8, 4};
    localparam int SD [2] = '{4, 3};
    localparam bit AL [2] = '{1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] hex_v   [2];
    logic [7:0]  dp_v    [2];
    logic [7:0]  blank_v [2];
    logic        en_v    [2];

    hex_scan_if #(.NUM_DIGITS(8)) ifa();
    hex_scan_if #(.NUM_DIGITS(4)) ifb();

    assign ifa.hex_in   = hex_v[0];
    assign ifa.dp_in    = dp_v[0];
    assign ifa.blank_in = blank_v[0];
    assign ifa.disp_en  = en_v[0];
    assign ifb.hex_in   = hex_v[1][15:0];
    assign ifb.dp_in    = dp_v[1][3:0];
    assign ifb.blank_in = blank_v[1][3:0];
    assign ifb.disp_en  = en_v[1];

    hex_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master)
    );
    hex_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(3), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master)
    );

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: clocks since reset release, snapshot, last expected frame.
    int          k         [2];
    int          last_done [2];
    logic [31:0] sh_hex    [2];
    logic [7:0]  sh_dp     [2];
    logic [7:0]  sh_blank  [2];
    logic        sh_en     [2];
    logic [15:0] e_frame   [2];
    int          e_idx     [2];
    logic        e_ld      [2];
    logic        e_done    [2];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [15:0] ref_frame(input int d, input int idx);
        logic [7:0]  seg;
        logic [7:0]  sel;
        logic [15:0] f;
        int          nib;
        nib = int'((sh_hex[d] >> (4 * idx)) & 32'hF);
        seg = {sh_dp[d][idx], segtab[nib]};
        if (sh_blank[d][idx]) seg = 8'h00;
        sel = 8'(1 << idx);
        if (!sh_en[d]) begin
            seg = 8'h00;
            sel = 8'h00;
        end
        f = {seg, sel};
        return AL[d] ? ~f : f;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] k=%0d: observed %h expected %h", tag, d, k[d], obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            k[d]         = 0;
            last_done[d] = 0;
            sh_hex[d]    = '0;
            sh_dp[d]     = '0;
            sh_blank[d]  = '0;
            sh_en[d]     = 1'b0;
            e_frame[d]   = AL[d] ? 16'hFFFF : 16'h0000;
            e_idx[d]     = 0;
        end
    endtask

    task automatic check_reset();
        chk("rst_frame", 0, 32'(ifa.frame_data), 32'hFFFF);
        chk("rst_ld",    0, 32'(ifa.frame_ld),   0);
        chk("rst_idx",   0, 32'(ifa.digit_idx),  0);
        chk("rst_done",  0, 32'(ifa.round_done), 0);
        chk("rst_frame", 1, 32'(ifb.frame_data), 32'h0000);
        chk("rst_ld",    1, 32'(ifb.frame_ld),   0);
    endtask

    // Each digit owns SD clocks; one extra snapshot clock closes every round.
    task automatic advance_model(input int d);
        int r;
        int m;
        r = ND[d] * SD[d] + 1;
        k[d]++;
        if ((k[d] - 1) % r == 0) begin
            sh_hex[d]   = hex_v[d];
            sh_dp[d]    = dp_v[d];
            sh_blank[d] = blank_v[d];
            sh_en[d]    = en_v[d];
        end
        e_ld[d]   = 1'b0;
        e_done[d] = 1'b0;
        if (k[d] >= 2) begin
            m = (k[d] - 2) % r;
            if (m < ND[d] * SD[d] && m % SD[d] == 0) begin
                e_ld[d]    = 1'b1;
                e_idx[d]   = m / SD[d];
                e_frame[d] = ref_frame(d, e_idx[d]);
            end
            e_done[d] = (m == ND[d] * SD[d] - 2);
        end
    endtask

    task automatic check_dut(input int d);
        logic [15:0] of;
        logic        ol;
        logic [2:0]  oi;
        logic        od;
        of = (d == 0) ? ifa.frame_data : ifb.frame_data;
        ol = (d == 0) ? ifa.frame_ld   : ifb.frame_ld;
        oi = (d == 0) ? ifa.digit_idx  : ifb.digit_idx;
        od = (d == 0) ? ifa.round_done : ifb.round_done;
        chk("frame_data", d, 32'(of), 32'(e_frame[d]));
        chk("frame_ld",   d, 32'(ol), 32'(e_ld[d]));
        chk("digit_idx",  d, 32'(oi), 32'(e_idx[d]));
        chk("round_done", d, 32'(od), 32'(e_done[d]));
        if (od) begin
            if (last_done[d] != 0)
                chk("round_period", d, 32'(k[d] - last_done[d]), 32'(ND[d] * SD[d] + 1));
            last_done[d] = k[d];
        end
    endtask

    task automatic step();
        @(posedge clk);
        advance_model(0);
        advance_model(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        hex_v[0] = 32'h0123_4567;  dp_v[0] = 8'h00;  blank_v[0] = 8'h00;  en_v[0] = 1'b1;
        hex_v[1] = 32'h0000_00A8;  dp_v[1] = 8'h00;  blank_v[1] = 8'h00;  en_v[1] = 1'b1;
        reset_model();
        #12;
        check_reset();
        @(negedge clk);
        rst = 1'b0;

        // Plain decode and round cadence on both instances.
        repeat (2 * 33 + 5) step();

        // Asynchronous reset in the middle of a dwell.
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        reset_model();

        // Input change while digit 3 is on screen must wait for the next round.
        repeat (15) step();
        hex_v[0] = 32'hFFFF_FFFF;
        hex_v[1] = 32'h0000_5E3C;
        repeat (2 * 33) step();

        // Blanking, decimal points, then display disable from the following round.
        blank_v[0] = 8'h01;  dp_v[0] = 8'h02;  hex_v[0] = 32'h89AB_CDEF;
        blank_v[1] = 8'h04;  dp_v[1] = 8'h09;
        repeat (40) step();
        en_v[0] = 1'b0;
        en_v[1] = 1'b0;
        repeat (2 * 33) step();
        en_v[0] = 1'b1;
        en_v[1] = 1'b1;

        // Random inputs, changed at arbitrary points in the round.
        repeat (500) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int d = 0; d < 2; d++) begin
                    hex_v[d]   = $urandom;
                    dp_v[d]    = 8'($urandom);
                    blank_v[d] = 8'($urandom) & 8'($urandom);
                    en_v[d]    = ($urandom_range(0, 3) != 0);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
